// File: rtl/bpred_btb.sv
// Branch target buffer with 2-bit saturating direction counters.
// Same-cycle lookup for fetch, write-back from the resolve stage,
// misprediction detection with a corrected PC, and saturating
// lookup/misprediction counters.
module bpred_btb #(
  parameter int         ADDR_SIZE = 32,
  parameter int         ENTRIES   = 16,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] pcF,
  input  logic                 lookup_en,
  output logic                 predtakenF,
  output logic [ADDR_SIZE-1:0] predpcF,
  input  logic                 upd_valid,
  input  logic [ADDR_SIZE-1:0] upd_pc,
  input  logic                 upd_isbr,
  input  logic                 upd_taken,
  input  logic [ADDR_SIZE-1:0] upd_target,
  input  logic                 upd_predtaken,
  input  logic [ADDR_SIZE-1:0] upd_predpc,
  output logic                 mispredict,
  output logic [ADDR_SIZE-1:0] redirect_pc,
  output logic [CNT_W-1:0]     nlookup,
  output logic [CNT_W-1:0]     nmispred
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_SIZE - 2 - IDX;

  logic [ENTRIES-1:0]   valid;
  logic [TAG_W-1:0]     tagMem    [ENTRIES];
  logic [ADDR_SIZE-1:0] targetMem [ENTRIES];
  logic [1:0]           ctrMem    [ENTRIES];

  logic [IDX-1:0]   idxF, idxU;
  logic [TAG_W-1:0] tagF, tagU;
  logic             hitF, hitU;
  logic [1:0]       ctrNext;
  logic             actualTaken;

  assign idxF = pcF[IDX+1:2];
  assign tagF = pcF[ADDR_SIZE-1:IDX+2];
  assign idxU = upd_pc[IDX+1:2];
  assign tagU = upd_pc[ADDR_SIZE-1:IDX+2];

  // Fetch-side lookup; reads pre-edge contents so a same-cycle update is not visible yet
  always_comb begin
    hitF       = valid[idxF] & (tagMem[idxF] == tagF);
    predtakenF = hitF & ctrMem[idxF][1];
    predpcF    = predtakenF ? targetMem[idxF] : pcF + ADDR_SIZE'(4);
  end

  // Resolve-side hit and the saturating counter step for the addressed entry
  always_comb begin
    hitU    = valid[idxU] & (tagMem[idxU] == tagU);
    ctrNext = ctrMem[idxU];
    if (upd_taken) begin
      if (ctrNext != 2'b11) ctrNext = ctrNext + 2'b01;
    end else begin
      if (ctrNext != 2'b00) ctrNext = ctrNext - 2'b01;
    end
  end

  // Misprediction detection and corrected next PC
  always_comb begin
    actualTaken = upd_isbr & upd_taken;
    mispredict  = upd_valid & ((upd_predtaken != actualTaken) |
                               (actualTaken & (upd_predpc != upd_target)));
    redirect_pc = actualTaken ? upd_target : upd_pc + ADDR_SIZE'(4);
  end

  // Valid bits and direction counters: reset-cleared, updated from resolve stage
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctrMem[IDX'(i)] <= CTR_INIT;
    end else if (upd_valid) begin
      if (upd_isbr) begin
        if (hitU) begin
          ctrMem[idxU] <= ctrNext;
        end else if (upd_taken) begin
          valid[idxU]  <= 1'b1;
          ctrMem[idxU] <= 2'b10;
        end
      end else if (hitU) begin
        valid[idxU] <= 1'b0;
      end
    end
  end

  // Tags and targets carry no reset; written on taken branches (refresh or allocate)
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_isbr && upd_taken) begin
      targetMem[idxU] <= upd_target;
      if (!hitU) tagMem[idxU] <= tagU;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      nlookup  <= '0;
      nmispred <= '0;
    end else begin
      if (lookup_en && (nlookup != '1))   nlookup  <= nlookup + CNT_W'(1);
      if (mispredict && (nmispred != '1)) nmispred <= nmispred + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Self-checking bench for bpred_btb: directed scenarios plus a randomized
// run against a per-index reference model of the BTB.
module tb_bpred_btb;

  localparam int AW   = 32;
  localparam int N    = 16;
  localparam int IDXW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pcF;
  logic          lookup_en;
  logic          predtakenF;
  logic [AW-1:0] predpcF;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic          upd_isbr;
  logic          upd_taken;
  logic [AW-1:0] upd_target;
  logic          upd_predtaken;
  logic [AW-1:0] upd_predpc;
  logic          mispredict;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   nlookup;
  logic [31:0]   nmispred;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  bpred_btb #(.ADDR_SIZE(32), .ENTRIES(16), .CTR_INIT(2'b01), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .pcF(pcF), .lookup_en(lookup_en),
    .predtakenF(predtakenF), .predpcF(predpcF),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_isbr(upd_isbr),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_predtaken(upd_predtaken), .upd_predpc(upd_predpc),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .nlookup(nlookup), .nmispred(nmispred)
  );

  // Reference model: each slot remembers the full PC it was allocated for
  bit            mValid [N];
  logic [AW-1:0] mPc    [N];
  logic [AW-1:0] mTgt   [N];
  int            mCtr   [N];
  longint        mNlook;
  longint        mNmis;

  function automatic int idxOf(logic [AW-1:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit mHit(logic [AW-1:0] pc);
    int i = idxOf(pc);
    return mValid[i] && ((mPc[i] >> (2 + IDXW)) == (pc >> (2 + IDXW)));
  endfunction

  function automatic bit mPredTaken(logic [AW-1:0] pc);
    return mHit(pc) && (mCtr[idxOf(pc)] >= 2);
  endfunction

  function automatic logic [AW-1:0] mPredPc(logic [AW-1:0] pc);
    return mPredTaken(pc) ? mTgt[idxOf(pc)] : pc + 32'd4;
  endfunction

  function automatic bit mMis();
    bit act = upd_isbr && upd_taken;
    return upd_valid && ((upd_predtaken != act) || (act && (upd_predpc != upd_target)));
  endfunction

  function automatic logic [AW-1:0] mRedirect();
    return (upd_isbr && upd_taken) ? upd_target : upd_pc + 32'd4;
  endfunction

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    int i;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        mValid[k] = 1'b0;
        mCtr[k]   = 1;
      end
      mNlook = 0;
      mNmis  = 0;
    end else begin
      if (lookup_en && mNlook < 64'hFFFF_FFFF) mNlook++;
      if (mMis() && mNmis < 64'hFFFF_FFFF) mNmis++;
      if (upd_valid) begin
        i = idxOf(upd_pc);
        if (upd_isbr) begin
          if (mHit(upd_pc)) begin
            mCtr[i] = upd_taken ? ((mCtr[i] == 3) ? 3 : mCtr[i] + 1)
                                : ((mCtr[i] == 0) ? 0 : mCtr[i] - 1);
            if (upd_taken) mTgt[i] = upd_target;
          end else if (upd_taken) begin
            mValid[i] = 1'b1;
            mPc[i]    = upd_pc;
            mTgt[i]   = upd_target;
            mCtr[i]   = 2;
          end
        end else if (mHit(upd_pc)) begin
          mValid[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    upd_valid     = 1'b0;
    upd_isbr      = 1'b0;
    upd_taken     = 1'b0;
    upd_predtaken = 1'b0;
    lookup_en     = 1'b0;
  endtask

  task automatic present(input logic [AW-1:0] pc, input logic isbr, input logic taken,
                         input logic [AW-1:0] tgt, input logic ptaken, input logic [AW-1:0] ppc);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_isbr      = isbr;
    upd_taken     = taken;
    upd_target    = tgt;
    upd_predtaken = ptaken;
    upd_predpc    = ppc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pcF   = 32'h0;
    idle();
    present(32'h100, 1'b1, 1'b1, 32'h999, 1'b0, 32'h104);
    tick();
    tick();
    reset = 1'b0;
    idle();
    pcF = 32'h100;
    #1;
    assertions++;
    if (predtakenF !== 1'b0) begin failures++; $display("FAIL reset_predtaken got %0b want 0", predtakenF); end
    assertions++;
    if (predpcF !== 32'h104) begin failures++; $display("FAIL reset_predpc got %h want 104", predpcF); end
    assertions++;
    if (nlookup !== 32'd0) begin failures++; $display("FAIL reset_nlookup got %0d want 0", nlookup); end
    assertions++;
    if (nmispred !== 32'd0) begin failures++; $display("FAIL reset_nmispred got %0d want 0", nmispred); end
  endtask

  task automatic test_alloc();
    present(32'h100, 1'b1, 1'b1, 32'h180, 1'b0, 32'h104);
    #1;
    assertions++;
    if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_mispredict got %0b want 1", mispredict); end
    assertions++;
    if (redirect_pc !== 32'h180) begin failures++; $display("FAIL alloc_redirect got %h want 180", redirect_pc); end
    tick();
    idle();
    pcF = 32'h100;
    #1;
    assertions++;
    if (predtakenF !== 1'b1) begin failures++; $display("FAIL alloc_predtaken got %0b want 1", predtakenF); end
    assertions++;
    if (predpcF !== 32'h180) begin failures++; $display("FAIL alloc_predpc got %h want 180", predpcF); end
    assertions++;
    if (nmispred !== 32'd1) begin failures++; $display("FAIL alloc_nmispred got %0d want 1", nmispred); end
  endtask

  task automatic test_counter();
    // counter starts at 2 after allocation: NT,NT,NT then T,T
    bit dirs [5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit expTk [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pcF = 32'h100;
    for (int s = 0; s < 5; s++) begin
      present(32'h100, 1'b1, dirs[s], 32'h180, 1'b0, 32'h104);
      tick();
      idle();
      #1;
      assertions++;
      if (predtakenF !== expTk[s]) begin
        failures++;
        $display("FAIL counter_step%0d_predtaken got %0b want %0b", s, predtakenF, expTk[s]);
      end
    end
    assertions++;
    if (predpcF !== 32'h180) begin failures++; $display("FAIL counter_predpc got %h want 180", predpcF); end
  endtask

  task automatic test_alias();
    present(32'h140, 1'b1, 1'b1, 32'h1c0, 1'b0, 32'h144);
    tick();
    idle();
    pcF = 32'h100;
    #1;
    assertions++;
    if (predpcF !== 32'h104 || predtakenF !== 1'b0) begin
      failures++; $display("FAIL alias_old_miss got %0b/%h want 0/104", predtakenF, predpcF);
    end
    pcF = 32'h140;
    #1;
    assertions++;
    if (predpcF !== 32'h1c0 || predtakenF !== 1'b1) begin
      failures++; $display("FAIL alias_new_hit got %0b/%h want 1/1c0", predtakenF, predpcF);
    end
    present(32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 32'h144);
    tick();
    idle();
    #1;
    assertions++;
    if (predpcF !== 32'h144 || predtakenF !== 1'b0) begin
      failures++; $display("FAIL alias_invalidate got %0b/%h want 0/144", predtakenF, predpcF);
    end
  endtask

  task automatic test_collision();
    present(32'h200, 1'b1, 1'b1, 32'h280, 1'b0, 32'h204);
    pcF = 32'h200;
    #1;
    assertions++;
    if (predtakenF !== 1'b0 || predpcF !== 32'h204) begin
      failures++; $display("FAIL collision_same_cycle got %0b/%h want 0/204", predtakenF, predpcF);
    end
    tick();
    idle();
    #1;
    assertions++;
    if (predtakenF !== 1'b1 || predpcF !== 32'h280) begin
      failures++; $display("FAIL collision_next_cycle got %0b/%h want 1/280", predtakenF, predpcF);
    end
  endtask

  task automatic test_wrong_target_reset();
    present(32'h2f0, 1'b1, 1'b1, 32'h340, 1'b1, 32'h300);
    #1;
    assertions++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h340) begin
      failures++; $display("FAIL wrong_target got %0b/%h want 1/340", mispredict, redirect_pc);
    end
    reset = 1'b1;
    #1;
    assertions++;
    if (mispredict !== 1'b1) begin failures++; $display("FAIL reset_mispredict_ungated got %0b want 1", mispredict); end
    tick();
    reset = 1'b0;
    idle();
    pcF = 32'h2f0;
    #1;
    assertions++;
    if (predtakenF !== 1'b0 || predpcF !== 32'h2f4) begin
      failures++; $display("FAIL reset_discard_update got %0b/%h want 0/2f4", predtakenF, predpcF);
    end
    assertions++;
    if (nmispred !== 32'd0) begin failures++; $display("FAIL reset_nmispred_prio got %0d want 0", nmispred); end
  endtask

  function automatic logic [AW-1:0] randPc();
    return 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2)
                    + 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [AW-1:0] upc;
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      lookup_en = $urandom_range(0, 1);
      pcF       = randPc();
      upc       = randPc();
      if ($urandom_range(0, 3) == 0) begin
        upd_valid = 1'b0;
        upd_pc    = upc;
      end else if ($urandom_range(0, 1) == 0) begin
        present(upc, ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
                32'h4000 + (32'($urandom_range(0, 7)) << 2), mPredTaken(upc), mPredPc(upc));
      end else begin
        present(upc, ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
                32'h4000 + (32'($urandom_range(0, 7)) << 2), $urandom_range(0, 1),
                32'h4000 + (32'($urandom_range(0, 7)) << 2));
      end
      #1;
      assertions++;
      if (predtakenF !== mPredTaken(pcF)) begin
        failures++; $display("FAIL rand_predtaken c%0d pc %h got %0b want %0b", c, pcF, predtakenF, mPredTaken(pcF));
      end
      assertions++;
      if (predpcF !== mPredPc(pcF)) begin
        failures++; $display("FAIL rand_predpc c%0d pc %h got %h want %h", c, pcF, predpcF, mPredPc(pcF));
      end
      assertions++;
      if (mispredict !== mMis()) begin
        failures++; $display("FAIL rand_mispredict c%0d got %0b want %0b", c, mispredict, mMis());
      end
      assertions++;
      if (upd_valid && redirect_pc !== mRedirect()) begin
        failures++; $display("FAIL rand_redirect c%0d got %h want %h", c, redirect_pc, mRedirect());
      end
      tick();
      assertions++;
      if (nlookup !== 32'(mNlook) || nmispred !== 32'(mNmis)) begin
        failures++;
        $display("FAIL rand_counters c%0d got %0d/%0d want %0d/%0d", c, nlookup, nmispred, mNlook, mNmis);
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    upd_pc     = '0;
    upd_target = '0;
    upd_predpc = '0;
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_collision();
    test_wrong_target_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined core's next-PC logic. It replaces the "always predict PC+4, flush on resolve" scheme. Fetch does a same-cycle lookup on pcF. The stage that resolves branches and jumps writes the outcome back through the update port. The block also flags mispredictions, supplies the corrected PC, and keeps saturating performance counters.

Parameters:
ADDR_SIZE, 32, width of PCs and targets.
ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX = log2(ENTRIES).
CTR_INIT, 2'b01, counter value loaded at reset (weakly not-taken).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
pcF  in  ADDR_SIZE  fetch PC to look up
lookup_en  in  1  fetch advances this cycle; gates the lookup counter only
predtakenF  out  1  prediction for pcF is taken
predpcF  out  ADDR_SIZE  predicted next PC
upd_valid  in  1  a resolved instruction is presented this cycle
upd_pc  in  ADDR_SIZE  PC of the resolved instruction
upd_isbr  in  1  resolved instruction is a branch, jal or jalr
upd_taken  in  1  actual direction (1 for jal/jalr)
upd_target  in  ADDR_SIZE  actual target when taken
upd_predtaken  in  1  predtakenF carried down the pipe with this instruction
upd_predpc  in  ADDR_SIZE  predpcF carried down the pipe with this instruction
mispredict  out  1  prediction was wrong; the pipe must flush and redirect
redirect_pc  out  ADDR_SIZE  correct next PC when mispredict is high
nlookup  out  CNT_W  number of lookups
nmispred  out  CNT_W  number of mispredictions

Behaviour:
- Storage per entry: valid, tag (ADDR_SIZE-2-IDX bits), target (ADDR_SIZE bits), ctr (2 bits).
- Addressing:
  - index = pc[IDX+1:2]
  - tag = pc[ADDR_SIZE-1:IDX+2]
  - pc[1:0] is ignored.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == tagF)
  - predtakenF = hit & ctr[idx][1]
  - predpcF = predtakenF ? target[idx] : pcF+4 (mod 2^ADDR_SIZE)
- Update (written at the clk edge when upd_valid=1 and reset=0):
  - upd_isbr=1, entry hits: counter moves +1 if upd_taken, -1 otherwise, saturating at 0 and 3. If upd_taken, target is overwritten with upd_target.
  - upd_isbr=1, miss, upd_taken=1: allocate. valid=1, tag and target written, ctr=2'b10. This replaces any prior occupant.
  - upd_isbr=1, miss, upd_taken=0: no change to storage.
  - upd_isbr=0, entry hits: valid cleared (an aliased non-branch removes a stale entry).
  - upd_isbr=0, miss: no change.
- Read/write collision: a lookup and an update to the same index in the same cycle return the OLD contents. The new contents are visible from the next cycle.
- Misprediction (combinational from the update inputs):
  - actual_taken = upd_isbr & upd_taken
  - mispredict = upd_valid & ((upd_predtaken != actual_taken) | (actual_taken & (upd_predpc != upd_target)))
  - redirect_pc = actual_taken ? upd_target : upd_pc+4
  - The external flush (D, E and M registers) is driven from mispredict, not from the taken signal.
- Counters:
  - nlookup increments on cycles with lookup_en=1.
  - nmispred increments on cycles with mispredict=1.
  - Both saturate at all-ones.
- Reset (synchronous):
  - At the edge: all valid bits cleared, every ctr set to CTR_INIT, nlookup=0, nmispred=0.
  - Tags and targets need no reset.
  - An update presented in a reset cycle is discarded.
  - After reset, predtakenF=0 and predpcF=pcF+4 for every pcF.
  - Reset asserted mid-stream takes priority over any pending update.
- Outputs are combinational and are not gated by reset. mispredict still reflects the upd_* inputs during a reset cycle.

Test Plan:
- Reset, then pcF=0x100 -> predtakenF=0, predpcF=0x104; nlookup=0, nmispred=0.
- Update pc=0x100, isbr=1, taken=1, target=0x180, predtaken=0 -> mispredict=1 and redirect_pc=0x180 that cycle. Next cycle pcF=0x100 gives predtakenF=1, predpcF=0x180, and nmispred=1.
- Counter: three not-taken updates to 0x100 -> ctr goes 10→01→00→00 (saturates); predtakenF=0 after the first. Two taken updates -> ctr=10, predtakenF=1.
- Alias (ENTRIES=16): allocate 0x100, then a taken update at 0x140 (same index, different tag) -> lookup 0x100 misses (predpcF=0x104); lookup 0x140 hits. A non-branch update at 0x140 -> entry invalidated.
- Same-cycle update and lookup at 0x200 (first allocation) -> predtakenF=0 that cycle, 1 the next.
- Wrong target: predtaken=1, predpc=0x300, actual target=0x340 -> mispredict=1, redirect_pc=0x340. Assert reset with a concurrent update -> no entry allocated; nmispred=0.
